// File: rtl/bcd_2of5_serial_enc.sv
// Serial multi-digit BCD to 2-out-of-5 encoder: one digit per clock, LSB digit first.
// Optional saturating invalid-digit counter on err_cnt, enabled by defining BCD2OF5_ERRCNT_EN.
module bcd_2of5_serial_enc #(
    parameter int NDIG = 4,
    parameter int CW   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] in_bcd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5*NDIG-1:0] out_code,
    output logic [NDIG-1:0]   out_err
`ifdef BCD2OF5_ERRCNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] bcd_q, bcd_d;
    logic [5*NDIG-1:0] code_q, code_d;
    logic [NDIG-1:0]   err_q, err_d;

    logic [3:0]        dig;
    logic [4:0]        dig_code;
    logic              dig_inv;
    logic              last_dig;

    always_comb begin
        dig = '0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (idx_q == k[CW-1:0]) dig = bcd_q[4*k +: 4];
        end
    end

    always_comb begin
        dig_inv = 1'b0;
        case (dig)
            4'd0:    dig_code = 5'b11000;
            4'd1:    dig_code = 5'b00011;
            4'd2:    dig_code = 5'b00101;
            4'd3:    dig_code = 5'b00110;
            4'd4:    dig_code = 5'b01001;
            4'd5:    dig_code = 5'b01010;
            4'd6:    dig_code = 5'b01100;
            4'd7:    dig_code = 5'b10001;
            4'd8:    dig_code = 5'b10010;
            4'd9:    dig_code = 5'b10100;
            default: begin
                dig_code = 5'b00000;
                dig_inv  = 1'b1;
            end
        endcase
    end

    assign last_dig = (idx_q == CW'(NDIG - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bcd_d   = bcd_q;
        code_d  = code_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    bcd_d   = in_bcd;
                    idx_d   = '0;
                    err_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                for (int unsigned k = 0; k < NDIG; k++) begin
                    if (idx_q == k[CW-1:0]) begin
                        code_d[5*k +: 5] = dig_code;
                        err_d[k]         = dig_inv;
                    end
                end
                idx_d = idx_q + 1'b1;
                if (last_dig) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            bcd_q   <= '0;
            code_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bcd_q   <= bcd_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_code  = code_q;
    assign out_err   = err_q;

`ifdef BCD2OF5_ERRCNT_EN
    logic [7:0] cnt_q, cnt_d;

    // Counts every invalid digit as it is converted; holds at 255.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == S_CONV) && dig_inv && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign err_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_bcd_2of5_serial_enc.sv
// Self-checking bench for bcd_2of5_serial_enc (NDIG=4): per-cycle word-level model plus directed literal checks.
module tb_bcd_2of5_serial_enc;

    localparam int NDIG = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [4*NDIG-1:0] in_bcd;
    logic              out_valid;
    logic              out_ready;
    logic [5*NDIG-1:0] out_code;
    logic [NDIG-1:0]   out_err;
`ifdef BCD2OF5_ERRCNT_EN
    logic [7:0]        err_cnt;
`endif

    bcd_2of5_serial_enc #(.NDIG(NDIG), .CW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_err   (out_err)
`ifdef BCD2OF5_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc_p   = 0;

    always @(posedge clk) cyc_p <= cyc_p + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic tmo(input string nm);
        n_total++;
        $display("FAIL %s: timeout waiting on DUT (t=%0t)", nm, $time);
    endtask

    // Word-level model: code table indexed by digit value.
    logic [4:0] code_tab [10] = '{5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
                                  5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100};

    function automatic logic [5*NDIG+NDIG-1:0] model_enc(input logic [4*NDIG-1:0] w);
        logic [5*NDIG-1:0] c;
        logic [NDIG-1:0]   e;
        int unsigned       d;
        c = '0;
        e = '0;
        for (int k = 0; k < NDIG; k++) begin
            d = (w >> (4*k)) & 32'hF;
            if (d > 9) e[k] = 1'b1;
            else       c[5*k +: 5] = code_tab[d];
        end
        return {c, e};
    endfunction

    function automatic int n_bad(input logic [4*NDIG-1:0] w);
        int n = 0;
        for (int k = 0; k < NDIG; k++) if (((w >> (4*k)) & 32'hF) > 9) n++;
        return n;
    endfunction

    // Model state: one word in flight; it becomes visible NDIG+1 sample points after acceptance.
    bit                busy     = 1'b0;
    int                cyc_n    = 0;
    int                ready_at = 0;
    logic [5*NDIG-1:0] exp_code;
    logic [NDIG-1:0]   exp_err;
    int                err_tot  = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy    = 1'b0;
            err_tot = 0;
        end else begin
            bit ev;
            cyc_n++;
            ev = busy && (cyc_n >= ready_at);
            chk("in_ready", in_ready, !busy);
            chk("out_valid", out_valid, ev);
            if (ev && out_valid) begin
                chk("out_code", out_code, exp_code);
                chk("out_err", out_err, exp_err);
            end
`ifdef BCD2OF5_ERRCNT_EN
            if (ev || !busy) chk("err_cnt", err_cnt, (err_tot > 255) ? 255 : err_tot);
`endif
            if (!busy && in_valid && in_ready) begin
                busy                = 1'b1;
                ready_at            = cyc_n + NDIG + 1;
                {exp_code, exp_err} = model_enc(in_bcd);
                err_tot             = err_tot + n_bad(in_bcd);
            end else if (ev && out_ready) begin
                busy = 1'b0;
            end
        end
    end

    task automatic send(input logic [15:0] w, input int hold, input bit lit,
                        input logic [19:0] ecode, input logic [3:0] eerr);
        int n;
        out_ready = (hold == 0);
        in_bcd    = w;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) tmo("accept");
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_bcd   = 16'($urandom);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (!out_valid) tmo("out_valid");
        else chk("latency", n + 1, NDIG + 1);
        if (lit) begin
            chk("lit_code", out_code, ecode);
            chk("lit_err", out_err, eerr);
        end
        if (hold > 0) begin
            repeat (hold) begin @(posedge clk); #1; end
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_ready", in_ready, 1'b0);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("released", out_valid, 1'b0);
    endtask

    initial begin
        logic [15:0] w;
        int          c0, n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bcd    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_code", out_code, '0);
        chk("rst_out_err", out_err, '0);
`ifdef BCD2OF5_ERRCNT_EN
        chk("rst_err_cnt", err_cnt, 8'd0);
`endif
        rst_n = 1'b1;

        chk("model_1234", model_enc(16'h1234), {20'b00011_00101_00110_01001, 4'b0000});
        chk("model_9870", model_enc(16'h9870), {20'b10100_10010_10001_11000, 4'b0000});
        chk("model_A0F5", model_enc(16'hA0F5), {20'b00000_11000_00000_01010, 4'b1010});

        repeat (2) @(posedge clk);
        #1;
        send(16'h1234, 0, 1'b1, 20'b00011_00101_00110_01001, 4'b0000);
        send(16'h9870, 0, 1'b1, 20'b10100_10010_10001_11000, 4'b0000);
        send(16'hA0F5, 0, 1'b1, 20'b00000_11000_00000_01010, 4'b1010);
`ifdef BCD2OF5_ERRCNT_EN
        chk("err_cnt_A0F5", err_cnt, 8'd2);
`endif
        send(16'h5678, 10, 1'b1, 20'b01010_01100_10001_10010, 4'b0000);

        // Reset two digits into a conversion.
        out_ready = 1'b1;
        in_bcd    = 16'h2468;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_code", out_code, '0);
        chk("midrst_out_err", out_err, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (NDIG + 3) @(posedge clk);
        #1;
        send(16'h4321, 0, 1'b1, 20'b01001_00110_00101_00011, 4'b0000);

        // Back-to-back acceptance with in_valid and out_ready held high.
        out_ready = 1'b1;
        in_bcd    = 16'h0519;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        c0     = cyc_p;
        in_bcd = 16'h7306;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) tmo("throughput");
        @(posedge clk); #1;
        chk("throughput", cyc_p - c0, NDIG + 2);
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) tmo("drain");

        // Every decimal digit in every position.
        for (int d = 0; d < 10; d++) begin
            for (int k = 0; k < NDIG; k++) w[4*k +: 4] = 4'((d + k) % 10);
            send(w, d % 3, 1'b0, '0, '0);
        end

`ifdef BCD2OF5_ERRCNT_EN
        for (int i = 0; i < 130; i++) send(16'hFFFF, 0, 1'b0, '0, '0);
        chk("err_cnt_sat", err_cnt, 8'd255);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
